mult_arbiter: RTL
=================

Name: mult_arbiter

Overview:
Shares one iterative multiplier, with a start/busy handshake, among NUM_REQ requesters such as cube-root and square-root sequencers. Grants are round-robin. The block launches each granted operation on the multiplier, waits for completion, and returns the product to the requester with a one-cycle ack. All multiplier traffic goes through this block; requesters never touch the multiplier directly.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
WIDTH, 8, operand width; the product is 2*WIDTH bits

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
req_i  in  NUM_REQ  per-requester operation request; level signal
a_i  in  NUM_REQ*WIDTH  packed operand A; slice k belongs to requester k
b_i  in  NUM_REQ*WIDTH  packed operand B; slice k belongs to requester k
ack_o  out  NUM_REQ  one-cycle pulse to the served requester; res_o is valid in that cycle
res_o  out  2*WIDTH  product of the last completed operation; held until the next completion
busy_o  out  1  high whenever the state is not IDLE
m_start_o  out  1  multiplier start, one-cycle pulse
m_a_o  out  WIDTH  multiplier operand A
m_b_o  out  WIDTH  multiplier operand B
m_busy_i  in  1  multiplier busy
m_res_i  in  2*WIDTH  multiplier result; valid when busy falls

Behaviour:
- Reset: state=IDLE, ack_o=0, res_o=0, busy_o=0, m_start_o=0, m_a_o=0, m_b_o=0, rr pointer=0, grant index=0.
- Reset mid-operation aborts the operation with no ack. The multiplier shares rst and is reset in the same cycle.
- FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE, DELIVER.
- IDLE, when any req_i bit is high:
  - Pick the first set bit at or above the rr pointer, wrapping modulo NUM_REQ.
  - Latch the grant index g.
  - Latch m_a_o / m_b_o from slices g of a_i / b_i.
  - Go to LAUNCH.
- LAUNCH: m_start_o=1 for this cycle only; go to WAIT_BUSY.
- WAIT_BUSY: stay until m_busy_i=1, then go to WAIT_DONE. The multiplier raises busy one cycle after it samples start.
- WAIT_DONE: stay while m_busy_i=1. On m_busy_i=0, capture m_res_i into res_o and go to DELIVER.
- DELIVER:
  - ack_o[g]=1 for this cycle.
  - rr pointer <= (g+1) mod NUM_REQ.
  - Go to IDLE.
- Operands are latched once, in IDLE. Changes to a_i/b_i after the grant do not affect the operation in flight.
- A requester that drops req_i before its ack still gets the operation completed and ack pulsed; the result is simply unused.
- Requester protocol: hold req_i high until ack. Keep it high in the ack cycle to queue another operation, which is re-arbitrated normally.
- Minimum gap between two acks is 4 cycles plus the multiplier latency. No requester ever gets two grants while another requester is continuously requesting (NUM_REQ-1 grants max in between).
- Arithmetic: res_o = a*b, full 2*WIDTH bits, unsigned, no truncation.
- At most one ack_o bit is high in any cycle.

Optional Feature:
MULT_ARB_LOCK_EN
- Enabled:
  - Adds input lock_i [NUM_REQ].
  - If lock_i[g]=1 during DELIVER, the rr pointer is not advanced. The next IDLE cycle grants g again if req_i[g]=1, so a requester can run chained multiplies (e.g. 3*y then *(y+1)) back to back.
  - If lock_i[g]=1 but req_i[g]=0 in IDLE, the lock is void and normal round-robin applies.
- Disabled: no lock_i port; the pointer always advances.

Decomposition:
- Package mult_arb_pkg holds:
  - the state enum,
  - default WIDTH/NUM_REQ constants,
  - the grant-index width function (clog2 of NUM_REQ).
- Sub-module rr_pick: combinational round-robin picker. Inputs are req and ptr; outputs are a valid flag and the grant index.
- The bench supplies a behavioural multiplier: busy one cycle after start, configurable latency, result a*b.

Test Plan:
1. Single requester 0, a=12, b=11 → one m_start_o pulse; ack_o=0001 with res_o=132; busy_o low afterwards.
2. All four requesters request together and hold (operands k+2, k+3) → ack order 0,1,2,3,0; results 6, 12, 20, 30.
3. Pointer=2 with requests on 0 and 3 only → requester 3 is served first, then 0.
4. Assert rst during WAIT_DONE with requester 1 active → no ack; all outputs at reset values next cycle; a new request is then served normally.
5. Operands 255*255 → res_o=65025. Operands 0*200 → res_o=0, ack still pulsed.
6. With MULT_ARB_LOCK_EN: requester 2 requests with lock while requester 3 is pending → two consecutive grants to 2, then 3. Dropping lock before the second DELIVER → requester 3 is granted next.

Source files
------------

// File: rtl/mult_arb_pkg.sv
// mult_arb_pkg
// Shared definitions for the multiplier arbiter: FSM state encoding,
// default sizing constants and the grant-index width helper.
// No ports (package).

package mult_arb_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_WIDTH   = 8;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_BUSY = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_DELIVER   = 3'd4
    } arb_state_t;

    // Bits needed to hold a requester index; never narrower than one bit.
    function automatic int grant_idx_w(input int num_req);
        return (num_req < 2) ? 1 : $clog2(num_req);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin picker: returns the first set request bit at or
// above the pointer, wrapping modulo NUM_REQ.
// Ports:
//   i_req   [NUM_REQ]  request vector
//   i_ptr   [IDX_W]    round-robin start position
//   o_valid            at least one request is set
//   o_idx   [IDX_W]    chosen requester index (0 when o_valid is low)

module rr_pick
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int IDX_W   = grant_idx_w(DEF_NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic               o_valid,
    output logic [IDX_W-1:0]   o_idx
);

    int w_cand;

    // Scan from the farthest offset down to the pointer itself so the
    // closest set bit (lowest offset) is the one that sticks.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_cand  = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            w_cand = (int'(i_ptr) + i) % NUM_REQ;
            if (i_req[w_cand]) begin
                o_valid = 1'b1;
                o_idx   = IDX_W'(w_cand);
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter
// Shares one iterative start/busy multiplier among NUM_REQ requesters with
// round-robin grants. Operands are latched at grant, the product is returned
// in res_o together with a one-cycle ack to the served requester.
//
// Optional feature macro: MULT_ARB_LOCK_EN
//   When defined, adds lock_i; a requester whose lock bit is high in DELIVER
//   keeps the round-robin pointer, so it wins the next arbitration if it is
//   still requesting (chained multiplies).
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   req_i     [N]       per-requester request level
//   a_i, b_i  [N*W]     packed operands, slice k belongs to requester k
//   lock_i    [N]       (MULT_ARB_LOCK_EN only) keep grant after delivery
//   ack_o     [N]       one-cycle completion pulse, res_o valid with it
//   res_o     [2W]      last completed product, held until next completion
//   busy_o              arbiter not idle
//   m_start_o           multiplier start pulse
//   m_a_o, m_b_o [W]    multiplier operands
//   m_busy_i            multiplier busy
//   m_res_i   [2W]      multiplier product, valid when busy falls
//
// State table:
//   state       | meaning
//   S_IDLE      | waiting for any request; grant + operand latch on exit
//   S_LAUNCH    | pulse multiplier start
//   S_WAIT_BUSY | wait for multiplier to acknowledge start with busy
//   S_WAIT_DONE | wait for busy to fall; capture product on exit
//   S_DELIVER   | pulse ack to granted requester, advance pointer

module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int WIDTH   = DEF_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_i,
    input  logic [NUM_REQ*WIDTH-1:0] a_i,
    input  logic [NUM_REQ*WIDTH-1:0] b_i,
`ifdef MULT_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]       lock_i,
`endif
    output logic [NUM_REQ-1:0]       ack_o,
    output logic [2*WIDTH-1:0]       res_o,
    output logic                     busy_o,
    output logic                     m_start_o,
    output logic [WIDTH-1:0]         m_a_o,
    output logic [WIDTH-1:0]         m_b_o,
    input  logic                     m_busy_i,
    input  logic [2*WIDTH-1:0]       m_res_i
);

    localparam int IDX_W = grant_idx_w(NUM_REQ);

    arb_state_t          r_state;
    arb_state_t          w_next_state;
    logic [IDX_W-1:0]    r_g;
    logic [IDX_W-1:0]    r_ptr;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic [2*WIDTH-1:0]  r_res;

    logic                w_pick_valid;
    logic [IDX_W-1:0]    w_pick_idx;
    logic [IDX_W-1:0]    w_ptr_adv;
    logic [IDX_W-1:0]    w_ptr_next;
    logic [NUM_REQ-1:0]  w_ack;
    logic                w_start;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .i_req   (req_i),
        .i_ptr   (r_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    // Pointer moves past the served requester; with locking enabled a locked
    // requester keeps the pointer on itself. If it has stopped requesting,
    // the picker simply scans onward from there, which is plain round-robin.
    always_comb begin
        w_ptr_adv = (int'(r_g) == NUM_REQ - 1) ? '0 : r_g + IDX_W'(1);
`ifdef MULT_ARB_LOCK_EN
        w_ptr_next = lock_i[r_g] ? r_g : w_ptr_adv;
`else
        w_ptr_next = w_ptr_adv;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_g     <= '0;
            r_ptr   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_IDLE && w_pick_valid) begin
                r_g <= w_pick_idx;
                r_a <= a_i[int'(w_pick_idx)*WIDTH +: WIDTH];
                r_b <= b_i[int'(w_pick_idx)*WIDTH +: WIDTH];
            end
            if (r_state == S_WAIT_DONE && !m_busy_i) begin
                r_res <= m_res_i;
            end
            if (r_state == S_DELIVER) begin
                r_ptr <= w_ptr_next;
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_ack        = '0;
        w_start      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_pick_valid) w_next_state = S_LAUNCH;
            end
            S_LAUNCH: begin
                w_start      = 1'b1;
                w_next_state = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (m_busy_i) w_next_state = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (!m_busy_i) w_next_state = S_DELIVER;
            end
            S_DELIVER: begin
                w_ack[r_g]   = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign ack_o     = w_ack;
    assign m_start_o = w_start;
    assign busy_o    = (r_state != S_IDLE);
    assign res_o     = r_res;
    assign m_a_o     = r_a;
    assign m_b_o     = r_b;

endmodule
